// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared defaults and FSM state encoding for the instruction fetch unit
package fetch_unit_pkg;

    localparam int IR_WIDTH_DEF   = 12;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF    = 15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_LOAD      = 2'd2,
        ST_WAIT_EXEC = 2'd3
    } fetch_state_t;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with synchronous load and wrapping increment
//
// Ports:
//   clk       clock
//   reset     synchronous active-low reset, clears pc to 0
//   load      load load_val into pc (takes priority over inc)
//   load_val  jump target
//   inc       advance pc by one, wrapping modulo 2^ADDR_width
//   pc        current program counter
module pc_counter #(
    parameter int ADDR_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_width-1:0] load_val,
    input  logic                  inc,
    output logic [ADDR_width-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            // Natural overflow of the fixed-width add gives the wrap to zero.
            pc <= pc + ADDR_width'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with memory-timeout detection
//
// Ports:
//   clk          clock
//   reset        synchronous active-low reset
//   start        level; begin fetching from pc while idle
//   mem_rd       memory read request (REQ only)
//   mem_addr     read address, always equal to pc
//   mem_ack      memory data valid this cycle
//   mem_rdata    memory read data
//   bus_data     registered instruction presented to the IR
//   ir_write_en  one-cycle IR load strobe (LOAD only)
//   exec_done    current instruction finished
//   pc_load      jump request, sampled with exec_done in WAIT_EXEC
//   pc_load_val  jump target
//   halt         return to IDLE after the current instruction
//   busy         high in every state except IDLE
//   mem_err      sticky memory-timeout flag
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int IR_width   = IR_WIDTH_DEF,
    parameter int ADDR_width = ADDR_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_rd,
    output logic [ADDR_width-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [IR_width-1:0]   mem_rdata,
    output logic [IR_width-1:0]   bus_data,
    output logic                  ir_write_en,
    input  logic                  exec_done,
    input  logic                  pc_load,
    input  logic [ADDR_width-1:0] pc_load_val,
    input  logic                  halt,
    output logic                  busy,
    output logic                  mem_err
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    fetch_state_t state, state_nxt;

    logic [CNT_W-1:0]      wait_cnt;
    logic                  timeout_hit;
    logic                  pc_inc;
    logic                  pc_jump;
    logic [ADDR_width-1:0] pc;

    // The last un-acked REQ cycle is the TIMEOUT-th one.
    assign timeout_hit = (state == ST_REQ) && !mem_ack
                      && (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign pc_inc  = (state == ST_LOAD);
    assign pc_jump = (state == ST_WAIT_EXEC) && exec_done && pc_load;

    pc_counter #(
        .ADDR_width (ADDR_width)
    ) u_pc_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_jump),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign mem_addr = pc;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start && !mem_err) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_nxt = ST_LOAD;
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_WAIT_EXEC;
            end
            ST_WAIT_EXEC: begin
                if (exec_done) begin
                    state_nxt = halt ? ST_IDLE : ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so they follow the registered state
    always_comb begin
        mem_rd      = 1'b0;
        ir_write_en = 1'b0;
        busy        = 1'b1;
        unique case (state)
            ST_IDLE:      busy        = 1'b0;
            ST_REQ:       mem_rd      = 1'b1;
            ST_LOAD:      ir_write_en = 1'b1;
            ST_WAIT_EXEC: ;
            default:      busy        = 1'b0;
        endcase
    end

    // Wait counter: runs only while a request is outstanding
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == ST_REQ && !mem_ack && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Instruction register and sticky error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_data <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (state == ST_REQ && mem_ack) begin
                bus_data <= mem_rdata;
            end
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
        end
    end

endmodule
